imem_loader: RTL
================

# imem_loader

Program loader for the single-cycle MIPS core: the write-side counterpart of the instruction-memory read port. Accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, writes them into instruction memory at consecutive word addresses, and holds the core in reset until the image is fully and correctly loaded. Sits between the board-level host link and the `MIPS` top level, which gains an instruction-memory write port and an external core-reset input.

## Interface
- `WIDTH`, 32, instruction word width; must be 32.
- `DEPTH`, 100, instruction-memory depth in words; loads longer than this are rejected.
- `CNT_BITS`, 7, width of `word_count`; must satisfy 2^CNT_BITS > DEPTH.

Ports:
- `CLK`  in  1  single clock, rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle pulse; begins a load. Sampled only in IDLE, DONE or ERROR.
- `word_count`  in  CNT_BITS  number of words to load; latched when `start` is accepted.
- `byte_valid`  in  1  `byte_data` is valid.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `mem_addr`  out  WIDTH  byte address, equal to word_index*4, matching PC addressing.
- `mem_wd`  out  WIDTH  assembled instruction word.
- `cpu_rst`  out  1  core reset, active-high.
- `busy`  out  1  load in progress.
- `done`  out  1  load completed successfully; sticky.
- `error`  out  1  load rejected; sticky.

## Operation
- FSM states: IDLE, LOAD, WRITE, CHECK (only when the checksum is compiled in), DONE, ERROR.
- IDLE:
  - `start` with `word_count`==0 goes to DONE.
  - `start` with `word_count`>DEPTH goes to ERROR.
  - Otherwise `start` goes to LOAD, clearing the word index, byte index and checksum accumulator.
- LOAD:
  - `byte_ready`=1.
  - Each handshake (`byte_valid`&&`byte_ready`) shifts the byte into the assembly register, MSB first: byte 0 becomes bits [31:24] and byte 3 becomes bits [7:0].
  - The 4th byte moves the FSM to WRITE.
- WRITE:
  - `byte_ready`=0 and `mem_we`=1 for exactly one cycle, with `mem_addr`=index*4 and `mem_wd`=the assembled word.
  - The index then increments.
  - If the index now equals `word_count`, go to CHECK (macro defined) or DONE. Otherwise return to LOAD.
- DONE: `done`=1 and `cpu_rst`=0, so the core starts fetching at PC 0.
- ERROR: `error`=1 and `cpu_rst`=1.
- From DONE or ERROR, `start` re-enters the IDLE decision in the same cycle and clears `done`/`error`.
- `start` in LOAD, WRITE or CHECK is ignored.
- `busy`=1 in LOAD, WRITE and CHECK.
- `cpu_rst`=1 in every state except DONE, and while `RST`=1.
- Reset mid-load:
  - Returns to IDLE and discards the partial word.
  - `mem_we` is 0 from the first post-reset cycle.
  - Memory contents already written are untouched.

## Timing
- Reset values:
  - FSM=IDLE.
  - `byte_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wd`=0.
  - `cpu_rst`=1, `busy`=0, `done`=0, `error`=0.
- All outputs are registered or decoded from registered state. No combinational path from `byte_valid` to `byte_ready`.
- `start` accepted at edge N: state (LOAD/DONE/ERROR) is visible in cycle N+1.
- 4th byte accepted at edge N: `mem_we` is high in cycle N+1 only.
- Peak throughput is 4 bytes per 5 cycles.
- After the last write, `done` (or CHECK's `byte_ready`) asserts in the next cycle.
- `cpu_rst` falls in the same cycle `done` rises.
- `byte_valid` may stay high across WRITE. No byte is lost or duplicated.

## Configuration
- Macro: `IMEM_LOADER_CHECKSUM_EN`.
- Defined:
  - After the last word the FSM enters CHECK with `byte_ready`=1 and accepts one trailer byte.
  - The 8-bit modular sum of all payload bytes plus the trailer must equal 0x00. If it does, go to DONE; otherwise go to ERROR.
  - The `word_count`==0 case skips CHECK.
- Undefined: no CHECK state and no accumulator. The FSM goes from WRITE to DONE directly, and no trailer byte is consumed.

## Test plan
- `word_count`=2, bytes 20 08 00 05 / 20 09 00 0A, `byte_valid` held high:
  - `mem_we` pulses twice: addr 0x0 with wd 0x20080005, then addr 0x4 with wd 0x2009000A.
  - `done`=1 and `cpu_rst`=0 exactly 1 cycle after the second write.
- Same load with `byte_valid` toggled every other cycle → identical writes. `byte_ready`=0 during each WRITE cycle.
- `word_count`=101 → `error`=1 next cycle, no `mem_we`, `cpu_rst` stays 1. `word_count`=0 → `done`=1 next cycle, no writes.
- `RST` asserted after 2 bytes of word 1:
  - IDLE next cycle, `mem_we` never pulses for that word.
  - A fresh `start` with `word_count`=1, bytes AC 0B 00 00 → write addr 0x0, wd 0xAC0B0000.
- Macro defined, `word_count`=1, bytes 01 02 03 04, trailer F6 → DONE. Trailer F7 → ERROR with `cpu_rst`=1. `start` pulsed from ERROR restarts the load.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream program loader for the MIPS instruction memory: packs big-endian words,
// writes them at consecutive word addresses and holds the core in reset until loaded.
// Optional trailer checksum when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 100,
    parameter int CNT_BITS = 7
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    input  logic [CNT_BITS-1:0] word_count,
    input  logic                byte_valid,
    input  logic [7:0]          byte_data,
    output logic                byte_ready,
    output logic                mem_we,
    output logic [WIDTH-1:0]    mem_addr,
    output logic [WIDTH-1:0]    mem_wd,
    output logic                cpu_rst,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [2:0]          dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK = 3'd3,
`endif
        DONE  = 3'd4,
        ERROR = 3'd5
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_BITS-1:0] word_idx;
    logic [CNT_BITS-1:0] word_cnt;
    logic [1:0]          byte_idx;
    logic [WIDTH-1:0]    asm_word;
    logic                start_ok;
    logic                take_byte;
    logic                last_word;
    state_t              start_dest;

    // Handshake: a byte transfers on a rising edge where byte_valid && byte_ready;
    // byte_ready depends on registered state only, never on byte_valid.
    assign byte_ready = (state == LOAD)
`ifdef IMEM_LOADER_CHECKSUM_EN
                        || (state == CHECK)
`endif
                        ;
    assign take_byte  = byte_valid && byte_ready;
    assign start_ok   = start && (state == IDLE || state == DONE || state == ERROR);
    assign last_word  = (word_idx + CNT_BITS'(1)) == word_cnt;

    always_comb begin
        start_dest = LOAD;
        if (word_count == '0)
            start_dest = DONE;
        else if (32'(word_count) > 32'(DEPTH))
            start_dest = ERROR;
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum;
    logic [7:0] csum_final;
    assign csum_final = csum + byte_data;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERROR: if (start_ok) state_nxt = start_dest;
            LOAD:  if (take_byte && byte_idx == 2'd3) state_nxt = WRITE;
`ifdef IMEM_LOADER_CHECKSUM_EN
            WRITE: state_nxt = last_word ? CHECK : LOAD;
            CHECK: if (take_byte) state_nxt = (csum_final == 8'h00) ? DONE : ERROR;
`else
            WRITE: state_nxt = last_word ? DONE : LOAD;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            word_idx <= '0;
            word_cnt <= '0;
            byte_idx <= '0;
            asm_word <= '0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                word_idx <= '0;
                byte_idx <= '0;
                word_cnt <= word_count;
            end
            if (state == LOAD && take_byte) begin
                asm_word <= {asm_word[WIDTH-9:0], byte_data};
                byte_idx <= byte_idx + 2'd1;
            end
            if (state == WRITE)
                word_idx <= word_idx + CNT_BITS'(1);
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running 8-bit sum of payload bytes; the trailer must bring it to zero.
    always_ff @(posedge CLK) begin
        if (RST)
            csum <= '0;
        else if (start_ok)
            csum <= '0;
        else if (state == LOAD && take_byte)
            csum <= csum_final;
    end
`endif

    assign mem_we    = (state == WRITE);
    assign mem_addr  = WIDTH'({word_idx, 2'b00});
    assign mem_wd    = asm_word;
    assign cpu_rst   = RST || (state != DONE);
    assign busy      = (state == LOAD) || (state == WRITE)
`ifdef IMEM_LOADER_CHECKSUM_EN
                       || (state == CHECK)
`endif
                       ;
    assign done      = (state == DONE);
    assign error     = (state == ERROR);
    assign dbg_state = state;

endmodule
